// File: rtl/decode_exec_latch_pkg.sv
// Shared types for the decode->exec boundary: register/word types, ALU and
// write-source encodings, forwarding selects and the latched decode bundle.
package decode_exec_latch_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR,  ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic [1:0] {
        WSRC_ALU, WSRC_MEM, WSRC_NPC, WSRC_LUI
    } write_t;

    typedef enum logic [1:0] {
        FWD_NONE, FWD_MEM, FWD_WB
    } fwd_sel_t;

    typedef struct packed {
        word_t    alu_in1;
        word_t    alu_in2;
        aluop_t   alu_aluop;
        regbits_t rs_alu_in;
        regbits_t rt_alu_in;
        logic     in2_uses_rt;
        regbits_t wsel;
        write_t   wdat_source;
        logic     branch_instr;
        logic     branch_taken;
        word_t    branch_target;
        logic     halt;
        word_t    instr_npc;
        logic     dmem_ren;
        logic     dmem_wen;
        word_t    dmemstore;
    } dec_t;

    // All-zero bundle: no register write, no memory access, no branch, no halt.
    localparam dec_t BUBBLE = '0;

endpackage

// File: rtl/decode_exec_latch_if.sv
// Decode->exec boundary bundle: decode fields and forwarding sources in,
// registered exec fields, forwarded operands and load-use stall out.
interface decode_exec_latch_if;
    import decode_exec_latch_pkg::*;

    logic     en;
    logic     flush;
    dec_t     dec;
    regbits_t mem_wsel;
    logic     mem_wen;
    word_t    mem_wdat;
    logic     mem_is_load;
    regbits_t wb_wsel;
    logic     wb_wen;
    word_t    wb_wdat;

    dec_t     ex;
    word_t    safe_alu_in1;
    word_t    safe_alu_in2;
    word_t    safe_dmemstore;
    fwd_sel_t in1_sel;
    fwd_sel_t in2_sel;
    fwd_sel_t store_sel;
    logic     hazard_stall;

    modport master (
        output en, flush, dec, mem_wsel, mem_wen, mem_wdat, mem_is_load,
               wb_wsel, wb_wen, wb_wdat,
        input  ex, safe_alu_in1, safe_alu_in2, safe_dmemstore,
               in1_sel, in2_sel, store_sel, hazard_stall
    );

    modport slave (
        input  en, flush, dec, mem_wsel, mem_wen, mem_wdat, mem_is_load,
               wb_wsel, wb_wen, wb_wdat,
        output ex, safe_alu_in1, safe_alu_in2, safe_dmemstore,
               in1_sel, in2_sel, store_sel, hazard_stall
    );

endinterface

// File: rtl/decode_exec_latch_fwd_mux.sv
// Per-operand MEM/WB bypass select; MEM beats WB, r0 and in-flight loads never forward.
// Latency: combinational (0 cycles).
// Backpressure: none; purely a function of its inputs.
module decode_exec_latch_fwd_mux
    import decode_exec_latch_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input  regbits_t r,
    input  logic     mem_wen,
    input  regbits_t mem_wsel,
    input  logic     mem_is_load,
    input  word_t    mem_wdat,
    input  logic     wb_wen,
    input  regbits_t wb_wsel,
    input  word_t    wb_wdat,
    input  word_t    latched,
    output word_t    data,
    output fwd_sel_t sel
);

    always_comb begin
        sel = FWD_NONE;
        if (FWD_EN && (r != '0)) begin
            // A load in MEM has no data yet; fall through to WB or the latched value.
            if (mem_wen && (mem_wsel == r) && !mem_is_load) begin
                sel = FWD_MEM;
            end else if (wb_wen && (wb_wsel == r)) begin
                sel = FWD_WB;
            end
        end
        case (sel)
            FWD_MEM: data = mem_wdat;
            FWD_WB:  data = wb_wdat;
            default: data = latched;
        endcase
    end

endmodule

// File: rtl/decode_exec_latch.sv
// Decode->exec pipeline register with flush/load-use bubbles, sticky halt and MEM/WB forwarding.
// Latency: 1 cycle decode->exec fields; forwarded operands combinational on latched regs.
// Backpressure: en=0 holds; load-use raises hazard_stall and injects a bubble so decode holds.
module decode_exec_latch
    import decode_exec_latch_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input logic                CLK,
    input logic                nRST,
    decode_exec_latch_if.slave bus
);

    dec_t ex_r;
    logic halted;
    logic stop;
    regbits_t in2_reg;

    // A halt sitting in exec freezes the latch on the same advance that retires it.
    assign stop = halted || (bus.en && ex_r.halt);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_r   <= BUBBLE;
            halted <= 1'b0;
        end else begin
            if (bus.en && ex_r.halt) begin
                halted <= 1'b1;
            end
            if (bus.flush || stop) begin
                ex_r <= BUBBLE;
            end else if (bus.en) begin
                ex_r <= bus.hazard_stall ? BUBBLE : bus.dec;
            end
        end
    end

    always_comb begin
        bus.ex      = ex_r;
        bus.ex.halt = ex_r.halt || halted;
    end

    assign bus.hazard_stall = ex_r.dmem_ren && (ex_r.wsel != '0) &&
        ((ex_r.wsel == bus.dec.rs_alu_in) ||
         ((ex_r.wsel == bus.dec.rt_alu_in) && (bus.dec.in2_uses_rt || bus.dec.dmem_wen)));

    // Immediate operands carry no source register, so present r0 to block forwarding.
    assign in2_reg = ex_r.in2_uses_rt ? ex_r.rt_alu_in : '0;

    decode_exec_latch_fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_in1 (
        .r(ex_r.rs_alu_in), .mem_wen(bus.mem_wen), .mem_wsel(bus.mem_wsel),
        .mem_is_load(bus.mem_is_load), .mem_wdat(bus.mem_wdat), .wb_wen(bus.wb_wen),
        .wb_wsel(bus.wb_wsel), .wb_wdat(bus.wb_wdat), .latched(ex_r.alu_in1),
        .data(bus.safe_alu_in1), .sel(bus.in1_sel)
    );

    decode_exec_latch_fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_in2 (
        .r(in2_reg), .mem_wen(bus.mem_wen), .mem_wsel(bus.mem_wsel),
        .mem_is_load(bus.mem_is_load), .mem_wdat(bus.mem_wdat), .wb_wen(bus.wb_wen),
        .wb_wsel(bus.wb_wsel), .wb_wdat(bus.wb_wdat), .latched(ex_r.alu_in2),
        .data(bus.safe_alu_in2), .sel(bus.in2_sel)
    );

    decode_exec_latch_fwd_mux #(.FWD_EN(FWD_EN)) u_fwd_store (
        .r(ex_r.rt_alu_in), .mem_wen(bus.mem_wen), .mem_wsel(bus.mem_wsel),
        .mem_is_load(bus.mem_is_load), .mem_wdat(bus.mem_wdat), .wb_wen(bus.wb_wen),
        .wb_wsel(bus.wb_wsel), .wb_wdat(bus.wb_wdat), .latched(ex_r.dmemstore),
        .data(bus.safe_dmemstore), .sel(bus.store_sel)
    );

endmodule
